// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_unit
// Brief    : Memory-stage stack engine: stack pointer, push/pop addressing,
//            and PC/CCR reassembly from popped words. Optional bounds guard
//            enabled by defining STACK_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stack_unit #(
  parameter int                ADDR_W  = 20,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        mem_data_sel,
  input  logic              pop_pc1,
  input  logic              pop_pc2,
  input  logic              pop_ccr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [31:0]       pc,
  input  logic [3:0]        ccr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] sp,
  output logic [31:0]       pc_restore,
  output logic              pc_restore_valid,
  output logic [3:0]        ccr_restore,
  output logic              ccr_restore_valid,
  output logic              stack_err
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CCR  = 2'd1,
    TAG_HI   = 2'd2,
    TAG_LO   = 2'd3
  } tag_e;

  logic [ADDR_W-1:0] sp_q, sp_d;
  tag_e              tag_q, tag_d;
  logic [15:0]       pc_hi_q, pc_hi_d;
  logic [15:0]       pc_hold_q, pc_hold_d;
  logic [31:0]       pc_restore_q, pc_restore_d;
  logic              pc_restore_valid_q, pc_restore_valid_d;
  logic [3:0]        ccr_restore_q, ccr_restore_d;
  logic              ccr_restore_valid_q, ccr_restore_valid_d;
  logic              stack_err_q, stack_err_d;

  logic pop_any, is_push, is_pop, collision, multi_pop;
  logic overflow, underflow, do_push, do_pop;
  logic [ADDR_W-1:0] sp_inc;

  always_comb begin
    pop_any   = pop_pc1 | pop_pc2 | pop_ccr;
    is_push   = stack & mem_wr;
    // A pop colliding with a push is dropped; the push wins.
    is_pop    = ((stack & mem_rd) | pop_any) & ~is_push;
    collision = is_push & ((stack & mem_rd) | pop_any);
    multi_pop = (pop_pc1 & pop_pc2) | (pop_pc1 & pop_ccr) | (pop_pc2 & pop_ccr);
    sp_inc    = sp_q + ADDR_W'(1);
`ifdef STACK_GUARD_EN
    overflow  = is_push & (sp_q == '0);
    underflow = is_pop & (sp_q == SP_INIT);
`else
    overflow  = 1'b0;
    underflow = 1'b0;
`endif
    do_push   = is_push & ~overflow;
    do_pop    = is_pop & ~underflow;
  end

  always_comb begin
    mem_addr  = alu_addr;
    mem_wdata = reg_data;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (rst) begin
      case (mem_data_sel)
        2'b01:   mem_wdata = pc[15:0];
        2'b10:   mem_wdata = pc_hold_q;
        2'b11:   mem_wdata = {{(DATA_W-4){1'b0}}, ccr};
        default: mem_wdata = reg_data;
      endcase
      if (is_push) begin
        mem_addr = sp_q;
        mem_we   = do_push;
      end else if (is_pop) begin
        mem_addr = sp_inc;
        mem_re   = do_pop;
      end else begin
        mem_we   = mem_wr;
        mem_re   = mem_rd;
      end
    end
  end

  always_comb begin
    sp_d                = sp_q;
    tag_d               = TAG_NONE;
    pc_hi_d             = pc_hi_q;
    pc_hold_d           = pc_hold_q;
    pc_restore_d        = pc_restore_q;
    pc_restore_valid_d  = 1'b0;
    ccr_restore_d       = ccr_restore_q;
    ccr_restore_valid_d = 1'b0;
    stack_err_d         = stack_err_q | collision | multi_pop | overflow | underflow;

    if (do_push) begin
      sp_d = sp_q - ADDR_W'(1);
      // Keep the high half so the second push word survives a PC change.
      if (mem_data_sel == 2'b01) pc_hold_d = pc[31:16];
    end else if (do_pop) begin
      sp_d = sp_inc;
      if (pop_ccr)      tag_d = TAG_CCR;
      else if (pop_pc2) tag_d = TAG_HI;
      else if (pop_pc1) tag_d = TAG_LO;
    end

    case (tag_q)
      TAG_HI: pc_hi_d = mem_rdata;
      TAG_LO: begin
        pc_restore_d       = {pc_hi_q, mem_rdata};
        pc_restore_valid_d = 1'b1;
        pc_hi_d            = '0;
      end
      TAG_CCR: begin
        ccr_restore_d       = mem_rdata[3:0];
        ccr_restore_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q                <= SP_INIT;
      tag_q               <= TAG_NONE;
      pc_hi_q             <= '0;
      pc_hold_q           <= '0;
      pc_restore_q        <= '0;
      pc_restore_valid_q  <= 1'b0;
      ccr_restore_q       <= '0;
      ccr_restore_valid_q <= 1'b0;
      stack_err_q         <= 1'b0;
    end else begin
      sp_q                <= sp_d;
      tag_q               <= tag_d;
      pc_hi_q             <= pc_hi_d;
      pc_hold_q           <= pc_hold_d;
      pc_restore_q        <= pc_restore_d;
      pc_restore_valid_q  <= pc_restore_valid_d;
      ccr_restore_q       <= ccr_restore_d;
      ccr_restore_valid_q <= ccr_restore_valid_d;
      stack_err_q         <= stack_err_d;
    end
  end

  assign sp                = sp_q;
  assign pc_restore        = pc_restore_q;
  assign pc_restore_valid  = pc_restore_valid_q;
  assign ccr_restore       = ccr_restore_q;
  assign ccr_restore_valid = ccr_restore_valid_q;
  assign stack_err         = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_unit
// Brief    : Scoreboard bench for stack_unit with a word-addressed memory and
//            a stack-semantics reference model. Honours STACK_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

  localparam int         ADDR_W  = 20;
  localparam logic [19:0] SP_INIT = 20'hFFFFF;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stack = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [1:0]  mem_data_sel = 2'b00;
  logic        pop_pc1 = 1'b0, pop_pc2 = 1'b0, pop_ccr = 1'b0;
  logic [19:0] alu_addr = '0;
  logic [15:0] reg_data = '0;
  logic [31:0] pc = '0;
  logic [3:0]  ccr = '0;
  logic [15:0] mem_rdata = '0;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [19:0] sp;
  logic [31:0] pc_restore;
  logic        pc_restore_valid;
  logic [3:0]  ccr_restore;
  logic        ccr_restore_valid;
  logic        stack_err;

  stack_unit #(.ADDR_W(ADDR_W), .DATA_W(16), .SP_INIT(SP_INIT)) dut (
    .clk(clk), .rst(rst), .stack(stack), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_sel(mem_data_sel), .pop_pc1(pop_pc1), .pop_pc2(pop_pc2),
    .pop_ccr(pop_ccr), .alu_addr(alu_addr), .reg_data(reg_data), .pc(pc),
    .ccr(ccr), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .sp(sp), .pc_restore(pc_restore),
    .pc_restore_valid(pc_restore_valid), .ccr_restore(ccr_restore),
    .ccr_restore_valid(ccr_restore_valid), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous data memory: read data valid the cycle after mem_re.
  logic [15:0] dmem [0:1048575];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dmem[mem_addr];
    if (mem_we) dmem[mem_addr] <= mem_wdata;
  end

  typedef struct {logic we; logic re; logic [19:0] addr; logic [15:0] wdata;} req_t;
  typedef struct {int c; logic [31:0] v;} rsp_t;
  req_t req_q[$];
  rsp_t exp_pc_q[$];
  rsp_t exp_ccr_q[$];

  // Reference model: stack of words in a flat memory, plus pending return-PC half.
  logic [15:0] m_mem [0:1048575];
  logic [19:0] m_sp = SP_INIT;
  logic [15:0] m_hold = '0, m_hi = '0;
  logic        m_err = 1'b0;
  logic [19:0] exp_sp = SP_INIT;
  logic        exp_err = 1'b0;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic s, rd, wr, input logic [1:0] sel,
                      input logic p2, p1, pcc, input logic [15:0] d,
                      input logic [31:0] pcv, input logic [3:0] ccv, input logic [19:0] alu);
    logic push_c, popreq, pop_c;
    logic [19:0] a;
    logic [15:0] w, dv;
    int np;
    @(posedge clk); #1;
    rst = 1'b1; stack = s; mem_rd = rd; mem_wr = wr; mem_data_sel = sel;
    pop_pc2 = p2; pop_pc1 = p1; pop_ccr = pcc; reg_data = d; pc = pcv; ccr = ccv;
    alu_addr = alu;
    exp_sp  = m_sp;
    exp_err = m_err;
    push_c = s & wr;
    popreq = (s & rd) | p1 | p2 | pcc;
    pop_c  = popreq & ~push_c;
    np = int'(p1) + int'(p2) + int'(pcc);
    if (push_c && popreq) m_err = 1'b1;
    if (np > 1) m_err = 1'b1;
    case (sel)
      2'b01:   w = pcv[15:0];
      2'b10:   w = m_hold;
      2'b11:   w = {12'h000, ccv};
      default: w = d;
    endcase
    if (push_c) begin
      if (GUARD && m_sp == 20'h0) m_err = 1'b1;
      else begin
        req_q.push_back('{we: 1'b1, re: 1'b0, addr: m_sp, wdata: w});
        m_mem[m_sp] = w;
        if (sel == 2'b01) m_hold = pcv[31:16];
        m_sp = m_sp - 20'd1;
      end
    end else if (pop_c) begin
      if (GUARD && m_sp == SP_INIT) m_err = 1'b1;
      else begin
        a  = m_sp + 20'd1;
        dv = m_mem[a];
        req_q.push_back('{we: 1'b0, re: 1'b1, addr: a, wdata: 16'h0});
        m_sp = a;
        if (pcc) exp_ccr_q.push_back('{c: cyc + 2, v: {28'h0, dv[3:0]}});
        else if (p2) m_hi = dv;
        else if (p1) begin
          exp_pc_q.push_back('{c: cyc + 2, v: {m_hi, dv}});
          m_hi = 16'h0;
        end
      end
    end else if (rd || wr) begin
      req_q.push_back('{we: wr, re: rd, addr: alu, wdata: w});
      if (wr) m_mem[alu] = w;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 2'b00, 0, 0, 0, 16'($urandom), 32'($urandom), 4'($urandom), 20'($urandom));
  endtask

  task automatic push(input logic [1:0] sel, input logic [15:0] d, input logic [31:0] pcv,
                      input logic [3:0] ccv);
    step(1, 0, 1, sel, 0, 0, 0, d, pcv, ccv, 20'($urandom));
  endtask

  task automatic pop(input logic p2, p1, pcc);
    step(~(p2 | p1 | pcc), ~(p2 | p1 | pcc), 0, 2'b00, p2, p1, pcc,
         16'($urandom), 32'($urandom), 4'($urandom), 20'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0; stack = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
    pop_pc1 = 1'b0; pop_pc2 = 1'b0; pop_ccr = 1'b0; mem_data_sel = 2'b00;
    reg_data = 16'($urandom); alu_addr = 20'($urandom);
    m_sp = SP_INIT; m_hold = '0; m_hi = '0; m_err = 1'b0;
    exp_sp = SP_INIT; exp_err = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Monitor: compares every presented request and restore pulse with the queues.
  always @(negedge clk) begin
    req_t r;
    rsp_t e;
    chk("sp", sp, exp_sp);
    chk("stack_err", stack_err, exp_err);
    if (!rst) begin
      chk("rst_mem_addr", mem_addr, alu_addr);
      chk("rst_mem_wdata", mem_wdata, reg_data);
      chk("rst_pc_restore", pc_restore, 0);
      chk("rst_ccr_restore", ccr_restore, 0);
    end
    if (mem_we || mem_re) begin
      if (req_q.size() == 0) chk("unexpected_req", {mem_we, mem_re}, 2'b00);
      else begin
        r = req_q.pop_front();
        chk("mem_we", mem_we, r.we);
        chk("mem_re", mem_re, r.re);
        chk("mem_addr", mem_addr, r.addr);
        if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
      end
    end else if (req_q.size() != 0) begin
      r = req_q.pop_front();
      chk("missing_req", {mem_we, mem_re}, {r.we, r.re});
    end
    if (pc_restore_valid) begin
      if (exp_pc_q.size() == 0) chk("unexpected_pc_valid", pc_restore_valid, 0);
      else begin
        e = exp_pc_q.pop_front();
        chk("pc_restore_cycle", cyc, e.c);
        chk("pc_restore", pc_restore, e.v);
      end
    end else if (exp_pc_q.size() != 0 && exp_pc_q[0].c <= cyc) begin
      e = exp_pc_q.pop_front();
      chk("missing_pc_valid", pc_restore_valid, 1);
    end
    if (ccr_restore_valid) begin
      if (exp_ccr_q.size() == 0) chk("unexpected_ccr_valid", ccr_restore_valid, 0);
      else begin
        e = exp_ccr_q.pop_front();
        chk("ccr_restore_cycle", cyc, e.c);
        chk("ccr_restore", ccr_restore, e.v);
      end
    end else if (exp_ccr_q.size() != 0 && exp_ccr_q[0].c <= cyc) begin
      e = exp_ccr_q.pop_front();
      chk("missing_ccr_valid", ccr_restore_valid, 1);
    end
  end

  initial begin
    do_reset(3);
    // Single data push, then call/ret pair with a PC change between halves.
    push(2'b00, 16'hBEEF, 32'h0, 4'h0);
    idle();
    push(2'b01, 16'h0, 32'h0001_2345, 4'h0);
    push(2'b10, 16'h0, 32'h0000_0200, 4'h0);
    pop(1, 0, 0);
    pop(0, 1, 0);
    repeat (3) idle();
    // Interrupt entry and RTI.
    push(2'b01, 16'h0, 32'hA5C3_7E10, 4'h0);
    push(2'b10, 16'h0, 32'h1111_2222, 4'h0);
    push(2'b11, 16'h0, 32'h0, 4'b1010);
    pop(0, 0, 1);
    pop(1, 0, 0);
    pop(0, 1, 0);
    pop(0, 0, 0);
    repeat (3) idle();
    // Pop from an empty stack.
    do_reset(2);
    pop(0, 0, 0);
    repeat (2) idle();
    // Push and pop together; then two pop strobes at once.
    do_reset(2);
    step(1, 1, 1, 2'b00, 0, 0, 0, 16'h1234, 32'h0, 4'h0, 20'h0);
    push(2'b00, 16'h5678, 32'h0, 4'h0);
    pop(0, 1, 1);
    repeat (3) idle();
    // Reset between the two halves of a return.
    do_reset(2);
    push(2'b01, 16'h0, 32'hCAFE_1234, 4'h0);
    push(2'b10, 16'h0, 32'h0, 4'h0);
    pop(1, 0, 0);
    do_reset(2);
    repeat (4) idle();
    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:    idle();
        1, 2: push(2'($urandom), 16'($urandom), 32'($urandom), 4'($urandom));
        3, 9: pop(0, 0, 0);
        4:    step(0, 1'($urandom), 1'($urandom), 2'($urandom), 0, 0, 0, 16'($urandom),
                   32'($urandom), 4'($urandom), 20'($urandom_range(0, 4095)));
        5: begin
          push(2'b01, 16'h0, 32'($urandom), 4'h0);
          push(2'b10, 16'h0, 32'($urandom), 4'h0);
          pop(1, 0, 0);
          pop(0, 1, 0);
        end
        6: begin
          push(2'b01, 16'h0, 32'($urandom), 4'h0);
          push(2'b10, 16'h0, 32'($urandom), 4'h0);
          push(2'b11, 16'h0, 32'h0, 4'($urandom));
          pop(0, 0, 1);
          pop(1, 0, 0);
          pop(0, 1, 0);
        end
        7:    pop(1'($urandom), 1'($urandom), 1'($urandom));
        default: step(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 16'($urandom), 32'($urandom),
                      4'($urandom), 20'($urandom_range(0, 4095)));
      endcase
    end
    repeat (6) idle();
    chk("req_queue_drained", req_q.size(), 0);
    chk("pc_queue_drained", exp_pc_q.size(), 0);
    chk("ccr_queue_drained", exp_ccr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
